// File: rtl/rift2_wb_pkg.sv
// rift2_wb_pkg: shared state, command and response types for the Rift2 Wishbone initiator.
package rift2_wb_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {IDLE, BUS, RESP} wb_mst_state_e;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
    logic [WB_SEL_W-1:0]  sel;
  } wb_cmd_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] dat;
    logic                 err;
  } wb_rsp_t;
endpackage

// File: rtl/rift2_wb_master.sv
// rift2_wb_master: single-transfer Wishbone classic initiator driven by a valid/ready command stream.
// Define RIFT2_WB_TIMEOUT_EN to abort transfers whose ack never arrives within TIMEOUT_CYC cycles.
module rift2_wb_master
  import rift2_wb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [3:0]        cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i
);
  wb_mst_state_e state_q, state_d;
  wb_cmd_t       cmd_q, cmd_d;
  wb_rsp_t       rsp_q, rsp_d;
  logic          cyc_q, cyc_d, rsp_valid_q, rsp_valid_d, timeout;

  if (DATA_W != WB_DATA_W || ADDR_W > WB_ADDR_W || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("rift2_wb_master: unsupported parameter set");
  end

`ifdef RIFT2_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Held at zero outside BUS so every transfer starts its budget afresh.
  always_comb cnt_d = state_q == BUS ? cnt_q + 1'b1 : '0;
  assign timeout = state_q == BUS && !wbm_ack_i && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid_i ? BUS : IDLE;
      BUS:     state_d = wbm_ack_i || timeout ? RESP : BUS;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d = cmd_q;
    rsp_d = rsp_q;
    if (state_q == IDLE && cmd_valid_i)
      cmd_d = '{we: cmd_we_i, adr: WB_ADDR_W'(cmd_adr_i), dat: cmd_dat_i, sel: cmd_sel_i};
    // Ack has priority over a timeout landing on the same edge.
    if (state_q == BUS && state_d == RESP)
      rsp_d = '{dat: timeout || cmd_q.we ? '0 : wbm_dat_i, err: timeout};
    cyc_d       = state_d == BUS;
    rsp_valid_d = state_d == RESP;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cmd_q       <= '0;
      rsp_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready_o = state_q == IDLE;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cmd_q.we;
  assign wbm_adr_o   = cmd_q.adr[ADDR_W-1:0];
  assign wbm_dat_o   = cmd_q.dat;
  assign wbm_sel_o   = cmd_q.sel;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
endmodule

// File: tb/tb_rift2_wb_master.sv
// tb_rift2_wb_master: scoreboard bench for the Wishbone initiator; stimulus pushes expected
// responses, a monitor pops them on each response handshake. Honours RIFT2_WB_TIMEOUT_EN.
module tb_rift2_wb_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;

  int          tests = 0;
  int          fails = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_rsp;
  logic        exp_we;
  logic [31:0] exp_adr, exp_dat;
  logic [3:0]  exp_sel;
  int          slv_wait = -1;
  int          stb_cnt = 0;
  int          stb_cycles = 0;
  logic        spur_ack = 1'b0;
  int          w;

  always #5 clk = ~clk;

  rift2_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int wt, input logic [31:0] rdat,
                       input bit push, input bit err, output int waited);
    logic rdy;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    waited = 0;
    while (!cmd_ready_o && waited < 200) begin
      tick();
      waited++;
    end
    rdy = cmd_ready_o;
    chk("cmd_accept", rdy, 1);
    tick();
    cmd_valid_i = 1'b0;
    exp_we = we;
    exp_adr = adr;
    exp_dat = dat;
    exp_sel = sel;
    slv_wait = wt;
    wbm_dat_i = rdat;
    stb_cycles = 0;
    if (push && rdy) sb.push_back({err ? 32'h0 : (we ? 32'h0 : rdat), err});
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk("drain", sb.size(), 0);
  endtask

  // Slave: acks on the (slv_wait+1)-th stb cycle and checks the request stays stable.
  initial forever begin
    @(posedge clk);
    #2;
    if (wbm_cyc_o && wbm_stb_o) begin
      stb_cnt++;
      stb_cycles++;
      chk("wb_hold", {wbm_we_o, wbm_adr_o, wbm_sel_o}, {exp_we, exp_adr, exp_sel});
      chk("wb_dat_hold", wbm_dat_o, exp_dat);
      wbm_ack_i = slv_wait >= 0 && stb_cnt == slv_wait + 1;
    end else begin
      stb_cnt = 0;
      wbm_ack_i = spur_ack;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_rsp: got dat=%h err=%b, required no response", rsp_dat_o, rsp_err_o);
      end else begin
        exp_rsp = sb.pop_front();
        chk("rsp_dat", rsp_dat_o, exp_rsp[32:1]);
        chk("rsp_err", rsp_err_o, exp_rsp[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'b0;
    cmd_adr_i = '0;
    cmd_dat_i = '0;
    cmd_sel_i = '0;
    rsp_ready_i = 1'b1;
    wbm_dat_i = '0;
    wbm_ack_i = 1'b0;
    #3;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_ctl", {wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_err_o}, 4'h0);
    chk("rst_rsp_dat", rsp_dat_o, 0);
    chk("rst_wb_out", {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}, 69'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'hA5A5_1234, 1, 0, w);
    drain();
    chk("read_stb_cycles", stb_cycles, 4);

    issue(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'h3, 0, 32'hFFFF_FFFF, 1, 0, w);
    chk("wr_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid_o}, {3'b111, 4'h3, 1'b0});
    tick();
    chk("wr_latency", {rsp_valid_o, wbm_cyc_o}, 2'b10);
    drain();
    chk("wr_stb_cycles", stb_cycles, 1);

    rsp_ready_i = 1'b0;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hC, 1, 32'h1357_9BDF, 1, 0, w);
    for (int i = 0; i < 20 && !rsp_valid_o; i++) tick();
    cmd_valid_i = 1'b1;
    cmd_we_i = 1'b1;
    cmd_adr_i = 32'h3000_0024;
    cmd_dat_i = 32'h0000_BEEF;
    cmd_sel_i = 4'h1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid_o, rsp_err_o, cmd_ready_o, rsp_dat_o}, {3'b100, 32'h1357_9BDF});
      tick();
    end
    rsp_ready_i = 1'b1;
    issue(1'b1, 32'h3000_0024, 32'h0000_BEEF, 4'h1, 0, 32'h1111_2222, 1, 0, w);
    chk("bp_accept_wait", w, 1);
    drain();

    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_ack_idle", {cmd_ready_o, wbm_cyc_o, rsp_valid_o}, 3'b100);
    end
    spur_ack = 1'b0;

    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF, 4, 32'h0F0F_0F0F, 1, 0, w);
    issue(1'b0, 32'h3000_0034, 32'h0, 4'h0, 0, 32'h7777_8888, 1, 0, w);
    chk("busy_accept_wait", w, 6);
    drain();

`ifdef RIFT2_WB_TIMEOUT_EN
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF, -1, 32'h5555_AAAA, 1, 1, w);
    drain();
    chk("timeout_stb_cycles", stb_cycles, 8);
    issue(1'b0, 32'h3000_0044, 32'h0, 4'hF, -1, 32'h5555_AAAA, 0, 0, w);
    tick();
    tick();
`else
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF, -1, 32'h5555_AAAA, 0, 0, w);
    for (int i = 0; i < 1000; i++) tick();
    chk("no_timeout_stb", {31'h0, wbm_stb_o, stb_cycles}, {32'h1, 32'd1000});
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_drop", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    @(negedge clk);
    chk("rst_no_rsp", rsp_valid_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst", {cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 3'b100);

    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, 2, 32'h0BAD_F00D, 1, 0, w);
    drain();
    chk("final_stb_cycles", stb_cycles, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rift2_wb_master.md
Name: rift2_wb_master

Overview:
- Wishbone classic single-transfer initiator: the master end of the wbs_* slave interface exposed by the Rift2 user-project wrapper.
- Converts a valid/ready command stream from core or test logic into one Wishbone cycle per command.
- Returns read data and status on a valid/ready response stream.
- One outstanding transfer at a time; no bursts and no pipelined stb.

Parameters:
- ADDR_W, 32, width of address on the command side and on Wishbone.
- DATA_W, 32, data width; must be 32.
- TIMEOUT_CYC, 255, maximum cycles with stb asserted before abort; used only when the optional feature is compiled in.

Ports:
- wb_clk_i  in  1  Wishbone clock; all logic on its rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_W  byte address, forwarded unchanged.
- cmd_dat_i  in  DATA_W  write data.
- cmd_sel_i  in  4  byte-lane select, forwarded unchanged (including 4'h0).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = transfer aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cyc.
- wbm_stb_o  out  1  Wishbone stb.
- wbm_we_o  out  1  Wishbone we.
- wbm_adr_o  out  ADDR_W  Wishbone address.
- wbm_dat_o  out  DATA_W  Wishbone write data.
- wbm_sel_o  out  4  Wishbone select.
- wbm_dat_i  in  DATA_W  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ack.

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - state IDLE.
  - All outputs 0, except cmd_ready_o, which is 1 in IDLE.
  - Timeout counter cleared.
- All wbm_* outputs, rsp_dat_o and rsp_err_o are registered. cmd_ready_o is decoded from state, asserted only in IDLE.
- FSM IDLE → BUS → RESP → IDLE:
  - IDLE: on cmd_valid_i at edge N, latch we/adr/dat/sel into wbm_* and go to BUS. cyc=stb=1 from N+1.
  - BUS: cyc, stb, we, adr, dat and sel are held stable until ack. On the edge where wbm_ack_i=1:
    - cyc and stb drop.
    - rsp_dat_o <= we ? 0 : wbm_dat_i.
    - rsp_err_o <= 0.
    - rsp_valid_o goes to 1; next state RESP.
  - Minimum latency: accept at N, ack sampled at N+1, rsp_valid_o high from N+2.
  - RESP: rsp_valid_o, rsp_dat_o and rsp_err_o are held until rsp_ready_i; then rsp_valid_o=0 and next state IDLE.
  - Earliest next accept is the cycle after the handshake, so there are no back-to-back cycles without an idle.
- wbm_ack_i while cyc=0 is ignored and changes no state.
- wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o retain their last values after cyc drops; only cyc/stb are qualifying.
- Reset mid-BUS: cyc and stb drop immediately (asynchronous). No response is produced for the aborted command.
- rsp_ready_i held high in IDLE or BUS has no effect.

Optional Feature:
- Macro: RIFT2_WB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYC+1) clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter equals TIMEOUT_CYC-1 and ack is absent, at that edge:
    - cyc and stb drop.
    - rsp_err_o <= 1 and rsp_dat_o <= 0.
    - state goes to RESP.
  - A simultaneous ack wins: normal response with err=0.
- Undefined: no counter is built; BUS waits indefinitely; rsp_err_o is constant 0.

Decomposition:
- Package rift2_wb_pkg:
  - state enum wb_mst_state_e {IDLE, BUS, RESP}.
  - WB_DATA_W=32 and WB_SEL_W=4.
  - packed struct wb_cmd_t {we, adr, dat, sel}.
  - packed struct wb_rsp_t {dat, err}.
- No sub-module: the FSM and counter are small enough to remain flat.

Test Plan:
- Read: cmd adr=32'h3000_0004, we=0, sel=4'hF; slave acks after 3 wait cycles with 32'hA5A5_1234 → cyc/stb high exactly 4 cycles, rsp_dat_o=32'hA5A5_1234, rsp_err_o=0.
- Write: adr=32'h3000_0010, dat=32'hCAFE_F00D, sel=4'h3; ack next cycle → wbm_we_o=1, wbm_sel_o=4'h3, data stable while stb=1, rsp_dat_o=0, rsp_valid_o high at N+2.
- Response backpressure: rsp_ready_i low for 5 cycles after a read → rsp_valid_o and data held; cmd_ready_o stays 0; new command accepted the cycle after the handshake.
- Spurious ack in IDLE, and cmd_valid_i in BUS/RESP → no response generated; second command not accepted until IDLE.
- RIFT2_WB_TIMEOUT_EN with TIMEOUT_CYC=8, slave never acks → stb high 8 cycles, then rsp_err_o=1 and rsp_dat_o=0. Without the macro, the same stimulus keeps stb high indefinitely (checked for 1000 cycles).
- wb_rst_ni pulled low during BUS → cyc/stb fall asynchronously before the next edge, no rsp_valid_o, cmd_ready_o=1 after release.
